smi_axi_input_fifo: RTL and testbench

Parametrised successor to the two-entry AXI-to-SELF input buffer. It accepts words on an AXI valid/ready input and presents them in order on a SELF valid/stop output, with a configurable depth and a registered fill-level output for upstream flow monitoring. It sits at the AXI boundary of SMI endpoints where a deeper elastic buffer is needed to absorb downstream stall bursts without stalling the AXI bus.

---
 rtl/smi_axi_input_fifo.sv | 104 ++++++++++
 tb/tb_smi_axi_input_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_axi_input_fifo.sv
// Parametrised AXI-to-SELF input FIFO with registered ready/valid flags
// and a registered fill level for upstream flow monitoring.
module smi_axi_input_fifo #(
    parameter int DataWidth     = 16,
    parameter int FifoIndexSize = 3,
    localparam int FifoDepth    = 2 ** FifoIndexSize
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   axiValid,
    input  logic [DataWidth-1:0]   axiDataIn,
    output logic                   axiReady,
    output logic                   dataOutValid,
    output logic [DataWidth-1:0]   dataOut,
    input  logic                   dataOutStop,
    output logic [FifoIndexSize:0] fifoLevel
);

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    localparam logic [FifoIndexSize:0]   LvlFull = (FifoIndexSize + 1)'(FifoDepth);
    localparam logic [FifoIndexSize:0]   LvlOne  = (FifoIndexSize + 1)'(1);
    localparam logic [FifoIndexSize-1:0] PtrOne  = FifoIndexSize'(1);

    state_e                 state_q;
    logic [DataWidth-1:0]   mem_q [FifoDepth];
    logic [FifoIndexSize-1:0] wr_ptr_q, wr_ptr_d;
    logic [FifoIndexSize-1:0] rd_ptr_q, rd_ptr_d;
    logic [FifoIndexSize:0] level_q, level_d;
    logic                   ready_q;
    logic                   valid_q;
    logic                   push;
    logic                   pop;

    assign push = axiValid & ready_q;
    assign pop  = valid_q & ~dataOutStop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end
    end

    // Ready stays low through the first post-reset cycle so it is never
    // seen high while the upstream master may still be in reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= StInit;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= (level_d != '0);
            unique case (state_q)
                StInit: begin
                    state_q <= StRun;
                    ready_q <= 1'b1;
                end
                StRun: begin
                    ready_q <= (level_d != LvlFull);
                end
                default: begin
                    state_q <= StInit;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= axiDataIn;
        end
    end

    assign axiReady     = ready_q;
    assign dataOutValid = valid_q;
    assign dataOut      = mem_q[rd_ptr_q];
    assign fifoLevel    = level_q;

endmodule

// File: tb/tb_smi_axi_input_fifo.sv
// Scoreboard testbench for smi_axi_input_fifo (16-bit data, depth 8).
module tb_smi_axi_input_fifo;

    localparam int DW    = 16;
    localparam int IDX   = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          srst;
    logic          axiValid;
    logic [DW-1:0] axiDataIn;
    logic          axiReady;
    logic          dataOutValid;
    logic [DW-1:0] dataOut;
    logic          dataOutStop;
    logic [IDX:0]  fifoLevel;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] m_q [$];
    logic          m_ready;
    logic          m_push;
    logic          m_pop;
    logic [DW-1:0] m_exp;
    logic [DW-1:0] obs_data;
    logic          obs_valid;

    always #5 clk = ~clk;

    smi_axi_input_fifo #(
        .DataWidth    (DW),
        .FifoIndexSize(IDX)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .axiValid    (axiValid),
        .axiDataIn   (axiDataIn),
        .axiReady    (axiReady),
        .dataOutValid(dataOutValid),
        .dataOut     (dataOut),
        .dataOutStop (dataOutStop),
        .fifoLevel   (fifoLevel)
    );

    // One clock of stimulus; the model decides push/pop from its own state.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
        axiValid    = v;
        axiDataIn   = d;
        dataOutStop = s;
        obs_data    = dataOut;
        obs_valid   = dataOutValid;
        m_push      = v && m_ready;
        m_pop       = (m_q.size() != 0) && !s;
        if (m_pop) m_exp = m_q.pop_front();
        if (m_push) m_q.push_back(d);
        @(posedge clk);
        #1;
        m_ready = (m_q.size() != DEPTH);
    endtask

    task automatic pulse_reset(input int n);
        srst        = 1'b1;
        axiValid    = 1'b0;
        dataOutStop = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        srst    = 1'b0;
        m_ready = 1'b0;
        m_q.delete();
    endtask

    task automatic test_reset;
        srst        = 1'b1;
        axiValid    = 1'b0;
        axiDataIn   = '0;
        dataOutStop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (axiReady !== 1'b0 || dataOutValid !== 1'b0 || fifoLevel !== 4'd0)
                $display("FAIL reset_hold cyc%0d: rdy=%b vld=%b lvl=%0d, need 0/0/0",
                         i, axiReady, dataOutValid, fifoLevel);
            else passed++;
        end
        srst    = 1'b0;
        m_ready = 1'b0;
        m_q.delete();
        total++;
        if (axiReady !== 1'b0 || dataOutValid !== 1'b0 || fifoLevel !== 4'd0)
            $display("FAIL reset_init: rdy=%b vld=%b lvl=%0d, need 0/0/0",
                     axiReady, dataOutValid, fifoLevel);
        else passed++;
        drive(1'b0, '0, 1'b0);
        total++;
        if (axiReady !== 1'b1 || dataOutValid !== 1'b0 || fifoLevel !== 4'd0)
            $display("FAIL reset_run: rdy=%b vld=%b lvl=%0d, need 1/0/0",
                     axiReady, dataOutValid, fifoLevel);
        else passed++;
    endtask

    task automatic test_fill_full;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            if (i == 8) begin
                total++;
                if (axiReady !== 1'b0 || fifoLevel !== 4'd8)
                    $display("FAIL full_flag: rdy=%b lvl=%0d, need 0/8", axiReady, fifoLevel);
                else passed++;
            end
        end
        total++;
        if (fifoLevel !== 4'd8 || dataOut !== 16'h0001 || dataOutValid !== 1'b1)
            $display("FAIL full_hold: lvl=%0d out=%h vld=%b, need 8/0001/1",
                     fifoLevel, dataOut, dataOutValid);
        else passed++;
        drive(1'b1, 16'h0009, 1'b0);
        total++;
        if (obs_data !== 16'h0001 || axiReady !== 1'b1 || fifoLevel !== 4'd7)
            $display("FAIL full_pop: out=%h rdy=%b lvl=%0d, need 0001/1/7",
                     obs_data, axiReady, fifoLevel);
        else passed++;
        drive(1'b1, 16'h0009, 1'b1);
        total++;
        if (fifoLevel !== 4'd8 || axiReady !== 1'b0)
            $display("FAIL full_refill: lvl=%0d rdy=%b, need 8/0", fifoLevel, axiReady);
        else passed++;
        for (int k = 2; k <= 9; k++) begin
            drive(1'b0, '0, 1'b0);
            total++;
            if (obs_data !== DW'(k) || m_exp !== DW'(k) || !m_pop)
                $display("FAIL full_drain: out=%h, need %h", obs_data, DW'(k));
            else passed++;
        end
        total++;
        if (dataOutValid !== 1'b0 || fifoLevel !== 4'd0)
            $display("FAIL full_empty: vld=%b lvl=%0d, need 0/0", dataOutValid, fifoLevel);
        else passed++;
    endtask

    task automatic test_streaming;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(16'h0100 + i), 1'b0);
            if (i > 0) begin
                total++;
                if (!obs_valid || obs_data !== DW'(16'h0100 + i - 1) || fifoLevel !== 4'd1)
                    $display("FAIL stream_%0d: vld=%b out=%h lvl=%0d, need 1/%h/1",
                             i, obs_valid, obs_data, fifoLevel, DW'(16'h0100 + i - 1));
                else passed++;
            end
        end
        drive(1'b0, '0, 1'b0);
        total++;
        if (obs_data !== 16'h0163 || dataOutValid !== 1'b0)
            $display("FAIL stream_last: out=%h vld=%b, need 0163/0", obs_data, dataOutValid);
        else passed++;
    endtask

    task automatic test_random;
        int words = 0;
        int errs  = 0;
        int cyc   = 0;
        while ((words < 10000 || m_q.size() != 0) && cyc < 60000) begin
            logic v;
            logic s;
            v = (words < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s = 1'($urandom_range(0, 1));
            drive(v, DW'($urandom), s);
            cyc++;
            if (m_push) words++;
            if (m_pop) begin
                total++;
                if (obs_data !== m_exp) begin
                    errs++;
                    if (errs < 10)
                        $display("FAIL rand_data: out=%h, need %h", obs_data, m_exp);
                end else passed++;
            end
            total++;
            if (fifoLevel !== (IDX+1)'(m_q.size()) || fifoLevel > 4'd8 ||
                axiReady !== m_ready || dataOutValid !== (m_q.size() != 0)) begin
                errs++;
                if (errs < 10)
                    $display("FAIL rand_flags: lvl=%0d rdy=%b vld=%b, need %0d/%b/%b",
                             fifoLevel, axiReady, dataOutValid, m_q.size(),
                             m_ready, (m_q.size() != 0));
            end else passed++;
        end
        total++;
        if (cyc >= 60000) $display("FAIL rand_timeout: words=%0d, need 10000", words);
        else passed++;
    endtask

    task automatic test_stall;
        logic [DW-1:0] want [3];
        want = '{16'hBEEF, 16'h1111, 16'h2222};
        drive(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 16'h1111, 1'b1);
            else if (i == 1) drive(1'b1, 16'h2222, 1'b1);
            else drive(1'b0, '0, 1'b1);
            total++;
            if (!obs_valid || obs_data !== 16'hBEEF || dataOut !== 16'hBEEF)
                $display("FAIL stall_hold_%0d: out=%h vld=%b, need BEEF/1",
                         i, obs_data, obs_valid);
            else passed++;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0);
            total++;
            if (!obs_valid || obs_data !== want[k])
                $display("FAIL stall_order_%0d: out=%h, need %h", k, obs_data, want[k]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'hA000 + i), 1'b1);
        total++;
        if (fifoLevel !== 4'd5)
            $display("FAIL mrst_pre: lvl=%0d, need 5", fifoLevel);
        else passed++;
        srst        = 1'b1;
        axiValid    = 1'b1;
        axiDataIn   = 16'hDEAD;
        dataOutStop = 1'b0;
        @(posedge clk);
        #1;
        srst    = 1'b0;
        m_ready = 1'b0;
        m_q.delete();
        total++;
        if (fifoLevel !== 4'd0 || dataOutValid !== 1'b0 || axiReady !== 1'b0)
            $display("FAIL mrst_clear: lvl=%0d vld=%b rdy=%b, need 0/0/0",
                     fifoLevel, dataOutValid, axiReady);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0);
            total++;
            if (dataOutValid !== 1'b0 || fifoLevel !== 4'd0)
                $display("FAIL mrst_stale_%0d: vld=%b lvl=%0d, need 0/0",
                         i, dataOutValid, fifoLevel);
            else passed++;
        end
        total++;
        if (axiReady !== 1'b1)
            $display("FAIL mrst_ready: rdy=%b, need 1", axiReady);
        else passed++;
        drive(1'b1, 16'h5A5A, 1'b0);
        drive(1'b0, '0, 1'b0);
        total++;
        if (obs_data !== 16'h5A5A || !obs_valid)
            $display("FAIL mrst_after: out=%h vld=%b, need 5A5A/1", obs_data, obs_valid);
        else passed++;
    endtask

    initial begin
        srst        = 1'b1;
        axiValid    = 1'b0;
        axiDataIn   = '0;
        dataOutStop = 1'b0;
        m_ready     = 1'b0;
        #1;
        test_reset();
        test_fill_full();
        test_streaming();
        test_random();
        test_stall();
        test_mid_reset();
        pulse_reset(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
